// File: rtl/xgmii_rx_link_monitor.sv
// XGMII RX link monitor: tracks local/remote fault ordered sets, reports link
// status, counts start and error characters, and stretches frame activity.
module xgmii_rx_link_monitor #(
  parameter int unsigned FAULT_THRESH = 4,
  parameter int unsigned CLEAR_WORDS  = 64,
  parameter int unsigned ACT_STRETCH  = 1048576
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] xgmii_rxd,
  input  logic [7:0]  xgmii_rxc,
  input  logic        rx_block_lock,
  output logic        link_up,
  output logic        local_fault,
  output logic        remote_fault,
  output logic        activity_led,
  output logic [31:0] frame_count,
  output logic [15:0] error_count
);

  localparam int unsigned SEQ_W = $clog2(FAULT_THRESH + 1);
  localparam int unsigned CLR_W = $clog2(CLEAR_WORDS + 1);
  localparam int unsigned STR_W = $clog2(ACT_STRETCH + 1);

  typedef enum logic [1:0] {ST_OK, ST_LF, ST_RF} state_t;

  state_t           state, state_next;
  logic [SEQ_W-1:0] seq_cnt, seq_next;
  logic [CLR_W-1:0] clr_cnt, clr_next;
  logic             trk_rf, trk_next;
  logic [STR_W-1:0] stretch;

  logic [1:0] m_lo, m_hi;
  logic       fault_word, fault_rf, err_word, start_hit;
  logic [1:0] start_num;

  // Returns {remote, local} match for one 4-lane column.
  function automatic logic [1:0] match_half(input logic [31:0] d, input logic [3:0] c);
    logic hdr;
    hdr = (c == 4'b0001) && (d[23:0] == 24'h00009C);
    return {hdr && (d[31:24] == 8'h02), hdr && (d[31:24] == 8'h01)};
  endfunction

  // Per-word decode; the lane-0 column decides the fault type when both match.
  always_comb begin
    m_lo       = match_half(xgmii_rxd[31:0], xgmii_rxc[3:0]);
    m_hi       = match_half(xgmii_rxd[63:32], xgmii_rxc[7:4]);
    fault_word = (|m_lo) || (|m_hi);
    fault_rf   = (|m_lo) ? m_lo[1] : m_hi[1];
    start_num  = 2'(xgmii_rxc[0] && (xgmii_rxd[7:0] == 8'hFB))
               + 2'(xgmii_rxc[4] && (xgmii_rxd[39:32] == 8'hFB));
    start_hit  = rx_block_lock && (start_num != 2'd0);
    err_word   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      err_word = err_word || (xgmii_rxc[k] && (xgmii_rxd[8*k +: 8] == 8'hFE));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_OK;
      seq_cnt <= '0;
      clr_cnt <= '0;
      trk_rf  <= 1'b0;
    end else begin
      state   <= state_next;
      seq_cnt <= seq_next;
      clr_cnt <= clr_next;
      trk_rf  <= trk_next;
    end
  end

  // Fault state machine; clr_cnt doubles as the quiet-word run length in OK.
  always_comb begin
    state_next = state;
    seq_next   = seq_cnt;
    clr_next   = clr_cnt;
    trk_next   = trk_rf;
    if (!rx_block_lock) begin
      state_next = ST_OK;
      seq_next   = '0;
      clr_next   = '0;
      trk_next   = 1'b0;
    end else begin
      case (state)
        ST_OK: begin
          if (seq_cnt == SEQ_W'(FAULT_THRESH)) begin
            state_next = trk_rf ? ST_RF : ST_LF;
            seq_next   = '0;
            clr_next   = fault_word ? '0 : CLR_W'(1);
          end else if (fault_word) begin
            clr_next = '0;
            if ((seq_cnt == '0) || (fault_rf != trk_rf)) begin
              seq_next = SEQ_W'(1);
              trk_next = fault_rf;
            end else begin
              seq_next = seq_cnt + SEQ_W'(1);
            end
          end else if (clr_cnt >= CLR_W'(CLEAR_WORDS - 1)) begin
            seq_next = '0;
            clr_next = '0;
          end else begin
            clr_next = clr_cnt + CLR_W'(1);
          end
        end
        ST_LF, ST_RF: begin
          if (fault_word) begin
            clr_next = '0;
            if (fault_rf != (state == ST_RF)) begin
              state_next = fault_rf ? ST_RF : ST_LF;
            end
          end else if (clr_cnt >= CLR_W'(CLEAR_WORDS - 1)) begin
            state_next = ST_OK;
            seq_next   = '0;
            clr_next   = '0;
          end else begin
            clr_next = clr_cnt + CLR_W'(1);
          end
        end
        default: state_next = ST_OK;
      endcase
    end
  end

  // Registered status, statistics and activity stretch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_up      <= 1'b0;
      local_fault  <= 1'b0;
      remote_fault <= 1'b0;
      activity_led <= 1'b0;
      stretch      <= '0;
      frame_count  <= '0;
      error_count  <= '0;
    end else begin
      link_up      <= rx_block_lock && (state == ST_OK);
      local_fault  <= (state == ST_LF);
      remote_fault <= (state == ST_RF);
      activity_led <= start_hit || (stretch != '0);
      if (start_hit) begin
        stretch <= STR_W'(ACT_STRETCH - 1);
      end else if (stretch != '0) begin
        stretch <= stretch - STR_W'(1);
      end
      if (rx_block_lock) begin
        frame_count <= frame_count + 32'(start_num);
        if (err_word && (error_count != 16'hFFFF)) begin
          error_count <= error_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_xgmii_rx_link_monitor.sv
// Scoreboard bench for xgmii_rx_link_monitor: directed words, expected output
// snapshots queued by cycle and compared by an independent monitor.
module tb_xgmii_rx_link_monitor;

  localparam logic [63:0] IDLE_D   = 64'h0707070707070707;
  localparam logic [63:0] LF_D     = 64'h0100009C0100009C;
  localparam logic [63:0] LFMIX_D  = 64'h0200009C0100009C;
  localparam logic [63:0] RFHI_D   = 64'h0200009C07070707;
  localparam logic [63:0] ST2_D    = 64'h555555FB555555FB;
  localparam logic [63:0] STHI_D   = 64'h070707FB07070707;
  localparam logic [63:0] STDAT_D  = 64'h00000000000000FB;
  localparam logic [63:0] ERR2_D   = 64'h07FE0707070707FE;
  localparam logic [63:0] ERRDAT_D = 64'h00000000000000FE;
  localparam logic [63:0] ERR1_D   = 64'hFE07070707070707;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] rxd;
  logic [7:0]  rxc;
  logic        lock;
  logic        link_up, local_fault, remote_fault, activity_led;
  logic [31:0] frame_count;
  logic [15:0] error_count;

  xgmii_rx_link_monitor #(
    .FAULT_THRESH(4),
    .CLEAR_WORDS (64),
    .ACT_STRETCH (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .xgmii_rxd    (rxd),
    .xgmii_rxc    (rxc),
    .rx_block_lock(lock),
    .link_up      (link_up),
    .local_fault  (local_fault),
    .remote_fault (remote_fault),
    .activity_led (activity_led),
    .frame_count  (frame_count),
    .error_count  (error_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned at;
    string       tag;
    logic [51:0] v;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned cap = 0;
  int unsigned ncmp = 0;
  int unsigned nfail = 0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  function automatic logic [51:0] pack(input logic lu, input logic lf, input logic rf,
                                       input logic led, input logic [31:0] fc,
                                       input logic [15:0] ec);
    return {lu, lf, rf, led, fc, ec};
  endfunction

  task automatic expect_at(input int unsigned at, input string tag, input logic lu,
                           input logic lf, input logic rf, input logic led,
                           input logic [31:0] fc, input logic [15:0] ec);
    exp_t e;
    e.at  = at;
    e.tag = tag;
    e.v   = pack(lu, lf, rf, led, fc, ec);
    sb.push_back(e);
  endtask

  task automatic check(input string tag, input logic [51:0] want);
    logic [51:0] got;
    got  = {link_up, local_fault, remote_fault, activity_led, frame_count, error_count};
    ncmp = ncmp + 1;
    if (got !== want) begin
      nfail = nfail + 1;
      $display("FAIL %s cyc=%0d: got lu=%b lf=%b rf=%b led=%b fc=%h ec=%h, want lu=%b lf=%b rf=%b led=%b fc=%h ec=%h",
               tag, cyc, got[51], got[50], got[49], got[48], got[47:16], got[15:0],
               want[51], want[50], want[49], want[48], want[47:16], want[15:0]);
    end
  endtask

  task automatic drive(input logic [63:0] d, input logic [7:0] c, input logic lk,
                       input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      rxd  = d;
      rxc  = c;
      lock = lk;
      cap  = cyc + 1;
    end
  endtask

  // Monitor: compares each queued snapshot in the cycle it names.
  initial begin
    exp_t m;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        m = sb.pop_front();
        if (m.at != cyc) begin
          ncmp  = ncmp + 1;
          nfail = nfail + 1;
          $display("FAIL %s: slot %0d passed unchecked, now cycle %0d", m.tag, m.at, cyc);
        end else begin
          check(m.tag, m.v);
        end
      end
    end
  end

  initial begin
    int unsigned b;
    exp_t        e;
    rst_n = 1'b0;
    rxd   = IDLE_D;
    rxc   = 8'hFF;
    lock  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", pack(0, 0, 0, 0, 32'd0, 16'd0));
    @(negedge clk);
    rst_n = 1'b1;
    cap   = cyc + 1;
    expect_at(cap, "no_lock", 0, 0, 0, 0, 32'd0, 16'd0);

    // Idle with lock
    b = cap + 1;
    expect_at(b,     "idle_link_up",  1, 0, 0, 0, 32'd0, 16'd0);
    expect_at(b + 2, "idle_steady",   1, 0, 0, 0, 32'd0, 16'd0);
    drive(IDLE_D, 8'hFF, 1'b1, 3);

    // Start/error counting and activity stretch
    b = cap + 1;
    expect_at(b,      "start_both",     1, 0, 0, 1, 32'd2, 16'd0);
    expect_at(b + 7,  "led_last",       1, 0, 0, 1, 32'd2, 16'd0);
    expect_at(b + 8,  "led_off",        1, 0, 0, 0, 32'd2, 16'd0);
    expect_at(b + 9,  "start_hi",       1, 0, 0, 1, 32'd3, 16'd0);
    expect_at(b + 10, "start_data",     1, 0, 0, 1, 32'd3, 16'd0);
    expect_at(b + 11, "err_two_lanes",  1, 0, 0, 1, 32'd3, 16'd1);
    expect_at(b + 12, "err_data_lane",  1, 0, 0, 1, 32'd3, 16'd1);
    expect_at(b + 13, "err_lane7",      1, 0, 0, 1, 32'd3, 16'd2);
    expect_at(b + 16, "led_last2",      1, 0, 0, 1, 32'd3, 16'd2);
    expect_at(b + 17, "led_off2",       1, 0, 0, 0, 32'd3, 16'd2);
    drive(ST2_D,    8'h11, 1'b1, 1);
    drive(IDLE_D,   8'hFF, 1'b1, 8);
    drive(STHI_D,   8'hFF, 1'b1, 1);
    drive(STDAT_D,  8'h00, 1'b1, 1);
    drive(ERR2_D,   8'hFF, 1'b1, 1);
    drive(ERRDAT_D, 8'h00, 1'b1, 1);
    drive(ERR1_D,   8'hFF, 1'b1, 1);
    drive(IDLE_D,   8'hFF, 1'b1, 9);

    // Local fault entry (one word also carries a remote set in the upper column)
    b = cap + 1;
    expect_at(b + 3,  "lf_count4",   1, 0, 0, 0, 32'd3, 16'd2);
    expect_at(b + 4,  "lf_enter",    1, 0, 0, 0, 32'd3, 16'd2);
    expect_at(b + 5,  "lf_asserted", 0, 1, 0, 0, 32'd3, 16'd2);
    expect_at(b + 67, "lf_hold",     0, 1, 0, 0, 32'd3, 16'd2);
    expect_at(b + 68, "lf_cleared",  1, 0, 0, 0, 32'd3, 16'd2);
    drive(LF_D,    8'h11, 1'b1, 2);
    drive(LFMIX_D, 8'h11, 1'b1, 1);
    drive(LF_D,    8'h11, 1'b1, 1);
    drive(IDLE_D,  8'hFF, 1'b1, 66);

    // Interrupted sequence: quiet run clears the count
    b = cap + 1;
    expect_at(b + 66,  "intr_gap",     1, 0, 0, 0, 32'd3, 16'd2);
    expect_at(b + 69,  "intr_no_lf",   1, 0, 0, 0, 32'd3, 16'd2);
    expect_at(b + 70,  "intr_no_lf2",  1, 0, 0, 0, 32'd3, 16'd2);
    expect_at(b + 135, "intr_settled", 1, 0, 0, 0, 32'd3, 16'd2);
    drive(LF_D,   8'h11, 1'b1, 3);
    drive(IDLE_D, 8'hFF, 1'b1, 64);
    drive(LF_D,   8'h11, 1'b1, 1);
    drive(IDLE_D, 8'hFF, 1'b1, 68);

    // Other-type word restarts the count
    b = cap + 1;
    expect_at(b + 5, "mixed_no_fault",  1, 0, 0, 0, 32'd3, 16'd2);
    expect_at(b + 6, "mixed_no_fault2", 1, 0, 0, 0, 32'd3, 16'd2);
    drive(LF_D,   8'h11, 1'b1, 3);
    drive(RFHI_D, 8'h1F, 1'b1, 1);
    drive(IDLE_D, 8'hFF, 1'b1, 68);

    // Direct LF -> RF switch, then reset while in RF
    b = cap + 1;
    expect_at(b + 5, "switch_before", 0, 1, 0, 0, 32'd3, 16'd2);
    expect_at(b + 6, "switch_to_rf",  0, 0, 1, 0, 32'd3, 16'd2);
    expect_at(b + 7, "rf_hold",       0, 0, 1, 0, 32'd3, 16'd2);
    drive(LF_D,   8'h11, 1'b1, 4);
    drive(IDLE_D, 8'hFF, 1'b1, 1);
    drive(RFHI_D, 8'h1F, 1'b1, 1);
    drive(IDLE_D, 8'hFF, 1'b1, 2);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_rf", pack(0, 0, 0, 0, 32'd0, 16'd0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cap   = cyc + 1;
    expect_at(cap, "after_reset_clean", 1, 0, 0, 0, 32'd0, 16'd0);

    // Lock drop freezes counters and ignores data
    b = cap + 1;
    expect_at(b,     "lock_start",    1, 0, 0, 1, 32'd2, 16'd0);
    expect_at(b + 1, "lock_drop",     0, 0, 0, 1, 32'd2, 16'd0);
    expect_at(b + 7, "lock_frozen",   0, 0, 0, 1, 32'd2, 16'd0);
    expect_at(b + 8, "lock_led_off",  0, 0, 0, 0, 32'd2, 16'd0);
    expect_at(b + 9, "lock_no_fault", 0, 0, 0, 0, 32'd2, 16'd0);
    drive(ST2_D,  8'h11, 1'b1, 1);
    drive(LF_D,   8'h11, 1'b0, 4);
    drive(ST2_D,  8'h11, 1'b0, 1);
    drive(ERR1_D, 8'hFF, 1'b0, 1);
    drive(LF_D,   8'h11, 1'b0, 1);
    drive(IDLE_D, 8'hFF, 1'b0, 2);

    // Error counter saturation
    b = cap + 1;
    expect_at(b,         "relock",    1, 0, 0, 0, 32'd2, 16'd0);
    expect_at(b + 1,     "err_first", 1, 0, 0, 0, 32'd2, 16'd1);
    expect_at(b + 65534, "err_fffe",  1, 0, 0, 0, 32'd2, 16'hFFFE);
    expect_at(b + 65535, "err_sat",   1, 0, 0, 0, 32'd2, 16'hFFFF);
    expect_at(b + 70000, "err_hold",  1, 0, 0, 0, 32'd2, 16'hFFFF);
    drive(IDLE_D, 8'hFF, 1'b1, 1);
    drive(ERR1_D, 8'hFF, 1'b1, 70000);
    drive(IDLE_D, 8'hFF, 1'b1, 2);

    repeat (4) @(negedge clk);
    #1;
    while (sb.size() > 0) begin
      e     = sb.pop_front();
      ncmp  = ncmp + 1;
      nfail = nfail + 1;
      $display("FAIL %s: slot %0d never checked", e.tag, e.at);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
